// File: rtl/cam_capture_rgb565.sv
// Camera byte-bus capture: OV7670-style pclk/vsync/href/data, sampled on the
// system clock and packed into RGB565 words for a linear frame buffer write port.
//
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   enable          capture enable (sampled only at frame boundaries)
//   cam_pclk        camera pixel clock, sampled as data
//   cam_vsync       frame sync (high between frames)
//   cam_href        line valid
//   cam_data        camera byte
//   addr_in         RAM write address (linear pixel index)
//   data_in         RAM write data {R5,G6,B5}
//   regwrite        one-cycle write strobe per completed pixel
//   frame_done      one-cycle pulse at the end of a captured frame
//   overflow        sticky: pixel arrived after the frame buffer was full
//   busy            high while capturing a frame
module cam_capture_rgb565 #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int AW    = 17,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          cam_pclk,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          frame_done,
    output logic          overflow,
    output logic          busy
);

    localparam logic [AW-1:0] FULL = AW'(IMG_W * IMG_H);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state, state_nx;

    // Two-stage synchronizers, equal depth on every bus signal so that the
    // byte and href seen at the strobe belong to the same pclk edge.
    logic [2:0] pclk_s;
    logic [2:0] vs_s;
    logic [1:0] href_s;
    logic [7:0] d_s1, d_s2;

    logic strobe, vs_rise, vs_fall;
    logic arm_start, cap_en, frame_end;
    logic ph_lo;
    logic [7:0] hi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_s <= '0;
            vs_s   <= '0;
            href_s <= '0;
            d_s1   <= '0;
            d_s2   <= '0;
        end else begin
            pclk_s <= {pclk_s[1:0], cam_pclk};
            vs_s   <= {vs_s[1:0], cam_vsync};
            href_s <= {href_s[0], cam_href};
            d_s1   <= cam_data;
            d_s2   <= d_s1;
        end
    end

    assign strobe  = pclk_s[1] & ~pclk_s[2];
    assign vs_rise = vs_s[1] & ~vs_s[2];
    assign vs_fall = ~vs_s[1] & vs_s[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        arm_start = 1'b0;
        cap_en    = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_nx = ARMED;
            end
            ARMED: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (vs_fall) begin
                    arm_start = 1'b1;
                    state_nx  = CAPTURE;
                end
            end
            CAPTURE: begin
                cap_en = 1'b1;
                if (vs_rise) begin
                    frame_end = 1'b1;
                    state_nx  = enable ? ARMED : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == CAPTURE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_in    <= '0;
            data_in    <= '0;
            regwrite   <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            ph_lo      <= 1'b0;
            hi_q       <= '0;
        end else begin
            regwrite   <= 1'b0;
            frame_done <= frame_end;

            // Address moves only after the write it labelled has been seen.
            if (regwrite) addr_in <= addr_in + 1'b1;

            if (arm_start) begin
                addr_in  <= '0;
                overflow <= 1'b0;
                ph_lo    <= 1'b0;
            end

            if (cap_en) begin
                if (!href_s[1]) begin
                    // Line ended: a lone high byte is discarded.
                    ph_lo <= 1'b0;
                end else if (strobe) begin
                    if (!ph_lo) begin
                        hi_q  <= d_s2;
                        ph_lo <= 1'b1;
                    end else begin
                        ph_lo <= 1'b0;
                        if (addr_in == FULL) begin
                            overflow <= 1'b1;
                        end else begin
                            data_in  <= DW'({hi_q, d_s2});
                            regwrite <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_rgb565.sv
// Scoreboard bench for cam_capture_rgb565 on a 4x2 frame: stimulus pushes
// expected {addr,data} words, a negedge monitor pops and compares each write.
module tb_cam_capture_rgb565;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 17;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          cam_pclk = 1'b0;
    logic          cam_vsync = 1'b1;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;
    logic          frame_done;
    logic          overflow;
    logic          busy;

    cam_capture_rgb565 #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .regwrite   (regwrite),
        .frame_done (frame_done),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic        prev_rw = 1'b0;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (regwrite) begin
            wr_cnt++;
            checks++;
            if (prev_rw) begin
                errors++;
                $display("FAIL back_to_back_regwrite got=1 want=0");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0d data=%h want none",
                         addr_in, data_in);
            end else begin
                mon_e = exp_q.pop_front();
                if ({addr_in, data_in} !== mon_e) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                             addr_in, data_in, mon_e[32:16], mon_e[15:0]);
                end
            end
        end
        prev_rw = regwrite;
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", n, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pclk_cycle(input logic [7:0] b);
        cam_data = b;
        cam_pclk = 1'b0;
        tick(4);
        cam_pclk = 1'b1;
        tick(4);
    endtask

    task automatic idle(input int n);
        repeat (n) pclk_cycle(8'h5A);
    endtask

    task automatic frame_start();
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        idle(3);
        cam_vsync = 1'b0;
        idle(3);
    endtask

    task automatic frame_end();
        cam_href  = 1'b0;
        idle(1);
        cam_vsync = 1'b1;
        idle(3);
    endtask

    task automatic send_pix(input logic [7:0] h, input logic [7:0] l,
                            input logic push, input logic [16:0] a);
        if (push) exp_q.push_back({a, h, l});
        cam_href = 1'b1;
        pclk_cycle(h);
        pclk_cycle(l);
    endtask

    task automatic drain(input string n);
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            tick(1);
            k++;
        end
        chk(n, exp_q.size(), 0);
        exp_q.delete();
    endtask

    int w0;
    int f0;

    initial begin
        // Reset with the bus active
        tick(1);
        for (int i = 0; i < 4; i++) begin
            cam_href  = 1'b1;
            cam_vsync = i[0];
            pclk_cycle(8'(i * 37));
        end
        chk("rst_addr", 32'(addr_in), 0);
        chk("rst_regwrite", 32'(regwrite), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;

        // Disabled: a full frame of traffic produces nothing
        frame_start();
        send_pix(8'h11, 8'h22, 1'b0, 17'd0);
        send_pix(8'h33, 8'h44, 1'b0, 17'd0);
        frame_end();
        chk("disabled_writes", 32'(wr_cnt), 0);
        chk("disabled_busy", 32'(busy), 0);

        // Single pixel
        enable = 1'b1;
        w0 = wr_cnt;
        f0 = fd_cnt;
        frame_start();
        chk("single_busy", 32'(busy), 1);
        send_pix(8'hF8, 8'h1F, 1'b1, 17'd0);
        drain("single_drain");
        frame_end();
        chk("single_count", 32'(wr_cnt - w0), 1);
        chk("single_frame_done", 32'(fd_cnt - f0), 1);
        chk("single_idle_busy", 32'(busy), 0);

        // Full 4x2 frame
        w0 = wr_cnt;
        f0 = fd_cnt;
        frame_start();
        for (int i = 0; i < W * H; i++)
            send_pix(8'(2 * i), 8'(2 * i + 1), 1'b1, 17'(i));
        drain("full_drain");
        chk("full_addr", 32'(addr_in), 8);
        frame_end();
        chk("full_count", 32'(wr_cnt - w0), 8);
        chk("full_frame_done", 32'(fd_cnt - f0), 1);
        chk("full_overflow", 32'(overflow), 0);

        // Overflow: nine pixels into an eight-word frame
        w0 = wr_cnt;
        frame_start();
        chk("ovf_start_addr", 32'(addr_in), 0);
        for (int i = 0; i < W * H + 1; i++)
            send_pix(8'(8'hA0 + i), 8'(8'h50 + i), (i < W * H), 17'(i));
        drain("ovf_drain");
        tick(8);
        chk("ovf_count", 32'(wr_cnt - w0), 8);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_addr", 32'(addr_in), 8);
        frame_end();
        chk("ovf_sticky", 32'(overflow), 1);
        frame_start();
        chk("ovf_cleared", 32'(overflow), 0);
        chk("ovf_addr_reset", 32'(addr_in), 0);

        // href drop after a lone high byte
        w0 = wr_cnt;
        cam_href = 1'b1;
        pclk_cycle(8'hAA);
        cam_href = 1'b0;
        idle(2);
        send_pix(8'h12, 8'h34, 1'b1, 17'd0);
        drain("href_drain");
        frame_end();
        chk("href_count", 32'(wr_cnt - w0), 1);

        // Reset mid-frame after three pixels
        frame_start();
        for (int i = 0; i < 3; i++)
            send_pix(8'(8'hC0 + i), 8'(8'h0C + i), 1'b1, 17'(i));
        drain("midrst_drain");
        chk("midrst_pre_addr", 32'(addr_in), 3);
        cam_href = 1'b0;
        rst_n = 1'b0;
        tick(2);
        chk("midrst_addr", 32'(addr_in), 0);
        chk("midrst_regwrite", 32'(regwrite), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_data", 32'(data_in), 0);
        rst_n = 1'b1;
        w0 = wr_cnt;
        frame_start();
        send_pix(8'hAB, 8'hCD, 1'b1, 17'd0);
        drain("midrst_new_drain");
        frame_end();
        chk("midrst_new_count", 32'(wr_cnt - w0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
